ps2_cursor_tracker: RTL and testbench
=====================================

Name: ps2_cursor_tracker

Overview:
Parametrised successor to the PS/2 packet-to-coordinate block. Takes decoded 3-/4-byte mouse packets from the PS/2 receiver and produces a clamped cursor position for any screen size, with programmable gain and packet-sync checking. Also produces button edge pulses and a left double-click pulse. Sits between the PS/2 packet assembler and the VGA cursor overlay and game logic.

Parameters:
H_RES, 640, horizontal pixel count; X clamps to [0, H_RES-1]
V_RES, 480, vertical pixel count; Y clamps to [0, V_RES-1]
COORD_W, 10, coordinate output width; requires 2^COORD_W >= max(H_RES, V_RES)
X_INIT, 320, X value after reset or recenter
Y_INIT, 240, Y value after reset or recenter
GAIN_SHIFT, 0, movement multiplier applied as a left shift by GAIN_SHIFT (range 0..3)
DBL_CYCLES, 25_000_000, maximum number of clk cycles between two left presses that counts as a double-click
CNT_W, 25, width of the double-click timer; requires 2^CNT_W > DBL_CYCLES

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
packet_done  in  1  one-cycle strobe; packet bytes are valid in this cycle
packet1  in  8  {YV,XV,YS,XS,1,M,R,L}
packet2  in  8  X magnitude
packet3  in  8  Y magnitude
packet4  in  8  wheel byte, two's complement; used only with WHEEL_EN
recenter  in  1  synchronous request to move the cursor to (X_INIT,Y_INIT)
mouse_x  out  COORD_W  cursor X
mouse_y  out  COORD_W  cursor Y (0 = top)
coord_valid  out  1  one-cycle pulse when mouse_x/mouse_y update
btn  out  3  {M,R,L} button levels
btn_press  out  3  one-cycle pulses on 0->1 transitions
btn_release  out  3  one-cycle pulses on 1->0 transitions
dbl_click  out  1  one-cycle pulse on a left double-click
wheel_pos  out  8  signed wheel accumulator (0 without WHEEL_EN)
sync_err  out  1  one-cycle pulse when a packet is rejected
err_count  out  8  number of rejected packets, saturates at 255

Behaviour:
- Reset: mouse_x=X_INIT, mouse_y=Y_INIT, wheel_pos=0, err_count=0, all pulse outputs and btn=0, timer idle, pipeline empty.
- Validity check: a packet with packet1[3]==0 is dropped. In the S1 capture cycle, sync_err pulses and err_count increments. Position, buttons and wheel are unchanged, and coord_valid stays low.
- Two-stage pipeline with no backpressure; one packet can be accepted every cycle.
- S1 (cycle after packet_done):
  - Delta formation: an overflow bit (XV/YV) saturates the delta to -256 or +255 according to the sign bit. Otherwise the 9-bit delta is {sign,magnitude}.
  - The delta is shifted left by GAIN_SHIFT into a signed register of width 9+GAIN_SHIFT.
  - Buttons update in this cycle: btn, btn_press and btn_release are registered here.
- S2 (second cycle after packet_done):
  - next_x = x + dx and next_y = y - dy, computed in signed COORD_W+GAIN_SHIFT+2 arithmetic with no wrap.
  - Results below 0 clamp to 0; results above the resolution clamp to H_RES-1 or V_RES-1.
  - coord_valid pulses in the same cycle the registers load.
- Latency: packet_done at cycle N gives buttons at N+1 and coordinates at N+2.
- recenter:
  - Takes effect on the next edge and pulses coord_valid.
  - If it coincides with an S2 update, recenter wins and the delta is discarded.
  - Buttons are not affected.
- Double-click FSM, states IDLE and ARMED:
  - IDLE: btn_press[0] loads the timer with DBL_CYCLES and moves to ARMED.
  - ARMED: the timer decrements each cycle.
  - ARMED, btn_press[0] with timer > 0: dbl_click pulses and the FSM goes to IDLE, so a third click re-arms it.
  - ARMED, timer reaches 0: go to IDLE.
  - Reset returns the FSM to IDLE.
- Reset asserted mid-pipeline flushes S1/S2; no coord_valid follows.

Optional Feature:
WHEEL_EN
- Defined: on each valid packet, packet4 sign-extended is added to wheel_pos in S2, saturating at -128/+127.
- Undefined: packet4 is ignored and wheel_pos is tied to 0.

Decomposition:
- Shared package ps2_pkg: packet1 bit-index constants (L=0, R=1, M=2, SYNC=3, XS=4, YS=5, XV=6, YV=7), OVF_POS=255, OVF_NEG=-256.
- One sub-module, ps2_axis_accum: it is instantiated twice, once for X and once for Y with the subtraction flag set. It contains delta formation, gain, signed accumulate and clamp for one axis, parametrised by RES, INIT and NEGATE.

Test Plan:
- Reset, then packet {0x08, 0x05, 0x03} -> at N+2 (325,237), coord_valid high for exactly 1 cycle.
- From (630,5), packet {0x08, 0x14, 0xF0} with YS=0 (dy=+240) -> clamps to (639,0); packet {0x58, 0x00, 0x00} (XV, XS) -> dx=-256, X=383.
- GAIN_SHIFT=2, from (320,240), dx=+10 -> X=360; dx=-128 -> X=0 (clamped, no wrap).
- Packet with packet1=0x01 (sync bit 0) -> sync_err pulse, err_count 0->1, btn unchanged; send 300 bad packets -> err_count holds 255.
- Left press, release, press 1000 cycles apart with DBL_CYCLES=5000 -> one dbl_click pulse; repeat 6000 cycles apart -> no pulse.
- recenter and an S2 update in the same cycle -> (X_INIT,Y_INIT). WHEEL_EN defined: packet4=0x7F twice -> wheel_pos=127.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 cursor tracker: packet1 bit positions,
// saturated overflow deltas and the double-click FSM state type.
package ps2_pkg;

  localparam int BIT_L    = 0;
  localparam int BIT_R    = 1;
  localparam int BIT_M    = 2;
  localparam int BIT_SYNC = 3;
  localparam int BIT_XS   = 4;
  localparam int BIT_YS   = 5;
  localparam int BIT_XV   = 6;
  localparam int BIT_YV   = 7;

  localparam logic signed [8:0] OVF_POS = 9'sd255;
  localparam logic signed [8:0] OVF_NEG = 9'sh100;  // -256

  typedef enum logic {
    DC_IDLE  = 1'b0,
    DC_ARMED = 1'b1
  } dc_state_t;

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: delta formation with overflow saturation, gain shift,
// signed accumulate (or subtract when NEGATE) and clamp to [0, RES-1].
module ps2_axis_accum
  import ps2_pkg::*;
#(
  parameter int RES        = 640,
  parameter int INIT       = 320,
  parameter int COORD_W    = 10,
  parameter int GAIN_SHIFT = 0,
  parameter bit NEGATE     = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               sign,
  input  logic               ovf,
  input  logic [7:0]         mag,
  input  logic               update,
  input  logic               recenter,
  output logic [COORD_W-1:0] coord
);

  localparam int DW = 9 + GAIN_SHIFT;
  localparam int AW = COORD_W + GAIN_SHIFT + 2;
  localparam logic signed [AW-1:0] MAX_S = AW'(RES - 1);

  logic signed [8:0]    d9;
  logic signed [DW-1:0] delta_q;
  logic signed [AW-1:0] cur_s;
  logic signed [AW-1:0] dlt_s;
  logic signed [AW-1:0] sum_s;
  logic [COORD_W-1:0]   clamped;

  always_comb begin
    if (ovf) d9 = sign ? OVF_NEG : OVF_POS;
    else     d9 = {sign, mag};
  end

  // Wide enough that neither the sum nor the difference can wrap.
  assign cur_s = AW'(coord);
  assign dlt_s = AW'(delta_q);
  assign sum_s = NEGATE ? (cur_s - dlt_s) : (cur_s + dlt_s);

  always_comb begin
    if (sum_s[AW-1])         clamped = '0;
    else if (sum_s > MAX_S)  clamped = COORD_W'(RES - 1);
    else                     clamped = sum_s[COORD_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      delta_q <= '0;
      coord   <= COORD_W'(INIT);
    end else begin
      if (load) delta_q <= DW'(d9) <<< GAIN_SHIFT;
      if (recenter)    coord <= COORD_W'(INIT);
      else if (update) coord <= clamped;
    end
  end

endmodule

// File: rtl/ps2_cursor_tracker.sv
// PS/2 packet to clamped cursor position, button edges and left double-click.
// Optional wheel accumulator enabled by defining WHEEL_EN.
//
// state    | meaning
// DC_IDLE  | waiting for a first left press
// DC_ARMED | timer running; a left press before it expires is a double-click
module ps2_cursor_tracker
  import ps2_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COORD_W    = 10,
  parameter int X_INIT     = 320,
  parameter int Y_INIT     = 240,
  parameter int GAIN_SHIFT = 0,
  parameter int DBL_CYCLES = 25_000_000,
  parameter int CNT_W      = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               packet_done,
  input  logic [7:0]         packet1,
  input  logic [7:0]         packet2,
  input  logic [7:0]         packet3,
  input  logic [7:0]         packet4,
  input  logic               recenter,
  output logic [COORD_W-1:0] mouse_x,
  output logic [COORD_W-1:0] mouse_y,
  output logic               coord_valid,
  output logic [2:0]         btn,
  output logic [2:0]         btn_press,
  output logic [2:0]         btn_release,
  output logic               dbl_click,
  output logic [7:0]         wheel_pos,
  output logic               sync_err,
  output logic [7:0]         err_count
);

  logic             pkt_ok;
  logic             pkt_bad;
  logic             s1_valid;
  dc_state_t        dc_state;
  logic [CNT_W-1:0] dbl_timer;

  assign pkt_ok  = packet_done &  packet1[BIT_SYNC];
  assign pkt_bad = packet_done & ~packet1[BIT_SYNC];

  ps2_axis_accum #(
    .RES(H_RES), .INIT(X_INIT), .COORD_W(COORD_W),
    .GAIN_SHIFT(GAIN_SHIFT), .NEGATE(1'b0)
  ) u_x (
    .clk(clk), .reset(reset), .load(pkt_ok),
    .sign(packet1[BIT_XS]), .ovf(packet1[BIT_XV]), .mag(packet2),
    .update(s1_valid), .recenter(recenter), .coord(mouse_x)
  );

  // Screen Y grows downward while PS/2 Y grows upward.
  ps2_axis_accum #(
    .RES(V_RES), .INIT(Y_INIT), .COORD_W(COORD_W),
    .GAIN_SHIFT(GAIN_SHIFT), .NEGATE(1'b1)
  ) u_y (
    .clk(clk), .reset(reset), .load(pkt_ok),
    .sign(packet1[BIT_YS]), .ovf(packet1[BIT_YV]), .mag(packet3),
    .update(s1_valid), .recenter(recenter), .coord(mouse_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      coord_valid <= 1'b0;
      btn         <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      sync_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      s1_valid    <= pkt_ok;
      coord_valid <= s1_valid | recenter;
      sync_err    <= pkt_bad;
      if (pkt_ok) begin
        btn         <= packet1[BIT_M:BIT_L];
        btn_press   <= packet1[BIT_M:BIT_L] & ~btn;
        btn_release <= ~packet1[BIT_M:BIT_L] & btn;
      end else begin
        btn_press   <= '0;
        btn_release <= '0;
      end
      if (pkt_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dc_state  <= DC_IDLE;
      dbl_timer <= '0;
      dbl_click <= 1'b0;
    end else begin
      dbl_click <= 1'b0;
      case (dc_state)
        DC_IDLE: begin
          if (btn_press[BIT_L]) begin
            dbl_timer <= CNT_W'(DBL_CYCLES);
            dc_state  <= DC_ARMED;
          end
        end
        DC_ARMED: begin
          if (btn_press[BIT_L] && dbl_timer != '0) begin
            dbl_click <= 1'b1;
            dc_state  <= DC_IDLE;
          end else if (dbl_timer == '0) begin
            dc_state <= DC_IDLE;
          end else begin
            dbl_timer <= dbl_timer - CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef WHEEL_EN
  logic signed [7:0] wheel_q;
  logic signed [8:0] wheel_sum;

  assign wheel_sum = $signed({wheel_pos[7], wheel_pos}) + $signed({wheel_q[7], wheel_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wheel_q   <= '0;
      wheel_pos <= '0;
    end else begin
      if (pkt_ok) wheel_q <= packet4;
      if (s1_valid) begin
        if (wheel_sum[8] != wheel_sum[7]) wheel_pos <= wheel_sum[8] ? 8'h80 : 8'h7F;
        else                              wheel_pos <= wheel_sum[7:0];
      end
    end
  end
`else
  logic wheel_unused;
  assign wheel_unused = ^packet4;
  assign wheel_pos    = 8'd0;
`endif

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Directed bench for ps2_cursor_tracker; a second instance runs with GAIN_SHIFT=2.
module tb_ps2_cursor_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       packet_done;
  logic [7:0] packet1, packet2, packet3, packet4;
  logic       recenter;

  logic [9:0] mouse_x, mouse_y, g_x, g_y;
  logic       coord_valid, g_cv;
  logic [2:0] btn, btn_press, btn_release, g_btn, g_press, g_release;
  logic       dbl_click, g_dbl, sync_err, g_serr;
  logic [7:0] wheel_pos, err_count, g_wheel, g_errc;

  int n_cmp = 0;
  int n_bad = 0;
  int dbl_seen = 0;

  always #5 clk = ~clk;

  ps2_cursor_tracker #(.GAIN_SHIFT(0), .DBL_CYCLES(5000), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .packet_done(packet_done),
    .packet1(packet1), .packet2(packet2), .packet3(packet3), .packet4(packet4),
    .recenter(recenter), .mouse_x(mouse_x), .mouse_y(mouse_y),
    .coord_valid(coord_valid), .btn(btn), .btn_press(btn_press),
    .btn_release(btn_release), .dbl_click(dbl_click), .wheel_pos(wheel_pos),
    .sync_err(sync_err), .err_count(err_count)
  );

  ps2_cursor_tracker #(.GAIN_SHIFT(2), .DBL_CYCLES(5000), .CNT_W(13)) dut_g (
    .clk(clk), .reset(reset), .packet_done(packet_done),
    .packet1(packet1), .packet2(packet2), .packet3(packet3), .packet4(packet4),
    .recenter(recenter), .mouse_x(g_x), .mouse_y(g_y),
    .coord_valid(g_cv), .btn(g_btn), .btn_press(g_press),
    .btn_release(g_release), .dbl_click(g_dbl), .wheel_pos(g_wheel),
    .sync_err(g_serr), .err_count(g_errc)
  );

  always @(negedge clk) if (dbl_click) dbl_seen++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the capture edge, when S1 outputs are visible.
  task automatic send(input logic [7:0] p1, input logic [7:0] p2,
                      input logic [7:0] p3, input logic [7:0] p4);
    packet1 = p1; packet2 = p2; packet3 = p3; packet4 = p4;
    packet_done = 1'b1;
    tick(1);
    packet_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_cmp++; if (coord_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cv_held: got %b want 0", coord_valid); end
    reset = 1'b0;
    tick(1);
    n_cmp++; if (mouse_x !== 10'd320) begin n_bad++; $display("FAIL rst_x: got %0d want 320", mouse_x); end
    n_cmp++; if (mouse_y !== 10'd240) begin n_bad++; $display("FAIL rst_y: got %0d want 240", mouse_y); end
    n_cmp++; if (btn !== 3'b000 || btn_press !== 3'b000 || btn_release !== 3'b000) begin n_bad++; $display("FAIL rst_btn: got %b/%b/%b want 000", btn, btn_press, btn_release); end
    n_cmp++; if (err_count !== 8'd0 || sync_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0d/%b want 0/0", err_count, sync_err); end
    n_cmp++; if (wheel_pos !== 8'd0 || dbl_click !== 1'b0 || coord_valid !== 1'b0) begin n_bad++; $display("FAIL rst_misc: got w=%0d d=%b cv=%b want 0", wheel_pos, dbl_click, coord_valid); end
  endtask

  task automatic test_basic();
    send(8'h08, 8'h05, 8'h03, 8'h00);
    n_cmp++; if (coord_valid !== 1'b0 || mouse_x !== 10'd320) begin n_bad++; $display("FAIL basic_n1: got cv=%b x=%0d want 0/320", coord_valid, mouse_x); end
    tick(1);
    n_cmp++; if (coord_valid !== 1'b1) begin n_bad++; $display("FAIL basic_cv: got %b want 1", coord_valid); end
    n_cmp++; if (mouse_x !== 10'd325 || mouse_y !== 10'd237) begin n_bad++; $display("FAIL basic_xy: got (%0d,%0d) want (325,237)", mouse_x, mouse_y); end
    tick(1);
    n_cmp++; if (coord_valid !== 1'b0) begin n_bad++; $display("FAIL basic_cv_pulse: got %b want 0", coord_valid); end
  endtask

  task automatic test_clamp();
    send(8'h08, 8'hFF, 8'hE8, 8'h00); tick(1);
    n_cmp++; if (mouse_x !== 10'd580 || mouse_y !== 10'd5) begin n_bad++; $display("FAIL clamp_step1: got (%0d,%0d) want (580,5)", mouse_x, mouse_y); end
    send(8'h08, 8'h32, 8'h00, 8'h00); tick(1);
    n_cmp++; if (mouse_x !== 10'd630 || mouse_y !== 10'd5) begin n_bad++; $display("FAIL clamp_step2: got (%0d,%0d) want (630,5)", mouse_x, mouse_y); end
    send(8'h08, 8'h14, 8'hF0, 8'h00); tick(1);
    n_cmp++; if (mouse_x !== 10'd639 || mouse_y !== 10'd0) begin n_bad++; $display("FAIL clamp_edges: got (%0d,%0d) want (639,0)", mouse_x, mouse_y); end
    send(8'h58, 8'h00, 8'h00, 8'h00); tick(1);
    n_cmp++; if (mouse_x !== 10'd383 || mouse_y !== 10'd0) begin n_bad++; $display("FAIL xv_neg: got (%0d,%0d) want (383,0)", mouse_x, mouse_y); end
    send(8'hA8, 8'h00, 8'h00, 8'h00); tick(1);
    n_cmp++; if (mouse_x !== 10'd383 || mouse_y !== 10'd256) begin n_bad++; $display("FAIL yv_neg: got (%0d,%0d) want (383,256)", mouse_x, mouse_y); end
  endtask

  task automatic test_back_to_back();
    recenter = 1'b1; tick(1); recenter = 1'b0;
    n_cmp++; if (coord_valid !== 1'b1 || mouse_x !== 10'd320 || mouse_y !== 10'd240) begin n_bad++; $display("FAIL recenter_plain: got cv=%b (%0d,%0d) want 1 (320,240)", coord_valid, mouse_x, mouse_y); end
    packet1 = 8'h08; packet2 = 8'h01; packet3 = 8'h01; packet_done = 1'b1;
    tick(1);
    packet2 = 8'h02; packet3 = 8'h02;
    tick(1);
    packet_done = 1'b0;
    n_cmp++; if (coord_valid !== 1'b1 || mouse_x !== 10'd321 || mouse_y !== 10'd239) begin n_bad++; $display("FAIL b2b_first: got cv=%b (%0d,%0d) want 1 (321,239)", coord_valid, mouse_x, mouse_y); end
    tick(1);
    n_cmp++; if (coord_valid !== 1'b1 || mouse_x !== 10'd323 || mouse_y !== 10'd237) begin n_bad++; $display("FAIL b2b_second: got cv=%b (%0d,%0d) want 1 (323,237)", coord_valid, mouse_x, mouse_y); end
    tick(1);
    n_cmp++; if (coord_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got cv=%b want 0", coord_valid); end
  endtask

  task automatic test_gain();
    recenter = 1'b1; tick(1); recenter = 1'b0;
    send(8'h08, 8'h0A, 8'h00, 8'h00); tick(1);
    n_cmp++; if (g_x !== 10'd360 || g_y !== 10'd240) begin n_bad++; $display("FAIL gain_pos: got (%0d,%0d) want (360,240)", g_x, g_y); end
    n_cmp++; if (mouse_x !== 10'd330) begin n_bad++; $display("FAIL gain0_pos: got %0d want 330", mouse_x); end
    send(8'h18, 8'h80, 8'h00, 8'h00); tick(1);
    n_cmp++; if (g_x !== 10'd0) begin n_bad++; $display("FAIL gain_neg_clamp: got %0d want 0", g_x); end
    n_cmp++; if (mouse_x !== 10'd202) begin n_bad++; $display("FAIL gain0_neg: got %0d want 202", mouse_x); end
  endtask

  task automatic test_sync();
    send(8'h0C, 8'h00, 8'h00, 8'h00);
    n_cmp++; if (btn !== 3'b100 || btn_press !== 3'b100) begin n_bad++; $display("FAIL m_press: got %b/%b want 100/100", btn, btn_press); end
    tick(1);
    send(8'h01, 8'h55, 8'h55, 8'h00);
    n_cmp++; if (sync_err !== 1'b1 || err_count !== 8'd1) begin n_bad++; $display("FAIL sync_err: got %b cnt=%0d want 1 cnt=1", sync_err, err_count); end
    n_cmp++; if (btn !== 3'b100 || btn_press !== 3'b000) begin n_bad++; $display("FAIL sync_btn: got %b/%b want 100/000", btn, btn_press); end
    tick(1);
    n_cmp++; if (coord_valid !== 1'b0 || sync_err !== 1'b0 || mouse_x !== 10'd202 || mouse_y !== 10'd240) begin n_bad++; $display("FAIL sync_drop: got cv=%b se=%b (%0d,%0d) want 0 0 (202,240)", coord_valid, sync_err, mouse_x, mouse_y); end
    send(8'h08, 8'h00, 8'h00, 8'h00);
    n_cmp++; if (btn !== 3'b000 || btn_release !== 3'b100) begin n_bad++; $display("FAIL m_release: got %b/%b want 000/100", btn, btn_release); end
    packet1 = 8'h01; packet_done = 1'b1;
    tick(300);
    packet_done = 1'b0;
    tick(1);
    n_cmp++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_sat: got %0d want 255", err_count); end
  endtask

  task automatic test_dbl_click();
    int base;
    base = dbl_seen;
    send(8'h09, 8'h00, 8'h00, 8'h00); tick(999);
    send(8'h08, 8'h00, 8'h00, 8'h00); tick(999);
    send(8'h09, 8'h00, 8'h00, 8'h00); tick(10);
    n_cmp++; if (dbl_seen - base !== 1) begin n_bad++; $display("FAIL dbl_fast: got %0d pulses want 1", dbl_seen - base); end
    send(8'h08, 8'h00, 8'h00, 8'h00); tick(999);
    send(8'h09, 8'h00, 8'h00, 8'h00); tick(999);
    n_cmp++; if (dbl_seen - base !== 1) begin n_bad++; $display("FAIL dbl_third_arms: got %0d pulses want 1", dbl_seen - base); end
    send(8'h08, 8'h00, 8'h00, 8'h00); tick(999);
    send(8'h09, 8'h00, 8'h00, 8'h00); tick(10);
    n_cmp++; if (dbl_seen - base !== 2) begin n_bad++; $display("FAIL dbl_fourth: got %0d pulses want 2", dbl_seen - base); end
    send(8'h08, 8'h00, 8'h00, 8'h00); tick(6000);
    send(8'h09, 8'h00, 8'h00, 8'h00); tick(6000);
    send(8'h08, 8'h00, 8'h00, 8'h00); tick(6000);
    send(8'h09, 8'h00, 8'h00, 8'h00); tick(10);
    n_cmp++; if (dbl_seen - base !== 2) begin n_bad++; $display("FAIL dbl_slow: got %0d pulses want 2", dbl_seen - base); end
  endtask

  task automatic test_recenter_collision();
    send(8'h09, 8'h40, 8'h40, 8'h00);
    recenter = 1'b1; tick(1); recenter = 1'b0;
    n_cmp++; if (coord_valid !== 1'b1 || mouse_x !== 10'd320 || mouse_y !== 10'd240) begin n_bad++; $display("FAIL recenter_wins: got cv=%b (%0d,%0d) want 1 (320,240)", coord_valid, mouse_x, mouse_y); end
    n_cmp++; if (btn !== 3'b001) begin n_bad++; $display("FAIL recenter_btn: got %b want 001", btn); end
    tick(1);
    n_cmp++; if (coord_valid !== 1'b0 || mouse_x !== 10'd320) begin n_bad++; $display("FAIL recenter_after: got cv=%b x=%0d want 0 320", coord_valid, mouse_x); end
  endtask

  task automatic test_reset_flush();
    send(8'h08, 8'h10, 8'h10, 8'h00);
    reset = 1'b1; tick(1);
    n_cmp++; if (coord_valid !== 1'b0 || mouse_x !== 10'd320) begin n_bad++; $display("FAIL flush_in_reset: got cv=%b x=%0d want 0 320", coord_valid, mouse_x); end
    reset = 1'b0; tick(1);
    n_cmp++; if (coord_valid !== 1'b0 || mouse_x !== 10'd320 || mouse_y !== 10'd240) begin n_bad++; $display("FAIL flush_after: got cv=%b (%0d,%0d) want 0 (320,240)", coord_valid, mouse_x, mouse_y); end
    n_cmp++; if (btn !== 3'b000 || err_count !== 8'd0) begin n_bad++; $display("FAIL flush_state: got btn=%b cnt=%0d want 000 0", btn, err_count); end
  endtask

  task automatic test_wheel();
    logic [7:0] want;
`ifdef WHEEL_EN
    want = 8'h7F;
`else
    want = 8'h00;
`endif
    send(8'h08, 8'h00, 8'h00, 8'h7F); tick(1);
    n_cmp++; if (wheel_pos !== want) begin n_bad++; $display("FAIL wheel_first: got %0d want %0d", wheel_pos, want); end
    send(8'h08, 8'h00, 8'h00, 8'h7F); tick(1);
    n_cmp++; if (wheel_pos !== want) begin n_bad++; $display("FAIL wheel_sat: got %0d want %0d", wheel_pos, want); end
  endtask

  initial begin
    reset = 1'b1; packet_done = 1'b0; recenter = 1'b0;
    packet1 = 8'h00; packet2 = 8'h00; packet3 = 8'h00; packet4 = 8'h00;
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_gain();
    test_sync();
    test_dbl_click();
    test_recenter_collision();
    test_reset_flush();
    test_wheel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
